// File: rtl/toggle_monitor_pkg.sv
// Shared types and default sizes for the toggle stream monitor.
// Holds the FSM state encoding and the counter widths.
package toggle_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int LOCK_CNT_DEF = 4;
    localparam int MISS_W_DEF   = 8;
    localparam int RUN_W        = 4;
    localparam int TOG_W        = 16;

endpackage

// File: rtl/toggle_edge_detect.sv
// Samples the toggle stream and produces the combinational toggle flag
// plus registered one-cycle rise/fall pulses.
module toggle_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic toggle,
    output logic rise,
    output logic fall
);

    logic din_q;

    // toggle compares the live input against the previous sample, so the
    // FSM acting on it and the rise/fall flops update on the same edge.
    assign toggle = din ^ din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            din_q <= din;
            rise  <= toggle & din;
            fall  <= toggle & ~din;
        end
    end

endmodule

// File: rtl/toggle_monitor.sv
// Lock monitor for an alternating bit stream: acquires lock after a run of
// consecutive toggles, flags and counts every loss of lock.
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int MISS_W   = MISS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              clr_err,
    output logic              rise,
    output logic              fall,
    output logic              locked,
    output logic              err,
    output logic [MISS_W-1:0] miss_cnt,
    output logic [TOG_W-1:0]  tog_cnt
);

    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             toggle;
    state_t           state_q;
    state_t           state_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [RUN_W-1:0] run_inc;
    logic             lose_lock;

    toggle_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .toggle (toggle),
        .rise   (rise),
        .fall   (fall)
    );

    assign run_inc = run_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            locked  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            // Decoded from next state so locked rises on the entry edge.
            locked  <= (state_d == LOCK);
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        lose_lock = 1'b0;
        case (state_q)
            IDLE: begin
                if (toggle) begin
                    state_d = ACQ;
                    run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
                end
            end
            ACQ: begin
                if (toggle) begin
                    run_d = run_inc;
                    if (run_inc == LOCK_RUN) begin
                        state_d = LOCK;
                    end
                end else begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            end
            LOCK: begin
                if (!toggle) begin
                    state_d   = FAULT;
                    lose_lock = 1'b1;
                end
            end
            FAULT: begin
                if (toggle) begin
                    state_d = ACQ;
                    run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            miss_cnt <= '0;
            tog_cnt  <= '0;
        end else begin
            if (toggle) begin
                tog_cnt <= tog_cnt + 1'b1;
            end
            // A loss of lock outranks a clear landing on the same edge; the
            // clear still applies first so the count restarts at one.
            if (lose_lock) begin
                err      <= 1'b1;
                miss_cnt <= clr_err ? {{(MISS_W-1){1'b0}}, 1'b1} : sat_inc(miss_cnt);
            end else if (clr_err) begin
                err      <= 1'b0;
                miss_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor: table of per-edge vectors followed by
// hand-written sequences for acquisition abort, saturation, wrap and reset.
module tb_toggle_monitor;

    logic        clk;
    logic        rst;
    logic        din;
    logic        clr_err;
    logic        rise;
    logic        fall;
    logic        locked;
    logic        err;
    logic [7:0]  miss_cnt;
    logic [15:0] tog_cnt;

    int n_total;
    int n_pass;

    typedef struct {
        logic        d;
        logic        c;
        logic        r;
        logic        f;
        logic        l;
        logic        e;
        logic [7:0]  m;
        logic [15:0] t;
    } vec_t;

    vec_t vecs[$];

    toggle_monitor #(.LOCK_CNT(4), .MISS_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .clr_err  (clr_err),
        .rise     (rise),
        .fall     (fall),
        .locked   (locked),
        .err      (err),
        .miss_cnt (miss_cnt),
        .tog_cnt  (tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all(input string nm, input logic r, input logic f, input logic l,
                           input logic e, input logic [7:0] m, input logic [15:0] t);
        chk(nm, {4'h0, rise, fall, locked, err, miss_cnt, tog_cnt},
                {4'h0, r, f, l, e, m, t});
    endtask

    task automatic add(input logic d, input logic c, input logic r, input logic f,
                       input logic l, input logic e, input logic [7:0] m, input logic [15:0] t);
        vec_t v;
        v.d = d; v.c = c; v.r = r; v.f = f; v.l = l; v.e = e; v.m = m; v.t = t;
        vecs.push_back(v);
    endtask

    task automatic step(input logic d, input logic c);
        @(negedge clk);
        din     = d;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        din     = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
    endtask

    initial begin
        logic cur;
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        din     = 1'b0;
        clr_err = 1'b0;

        //  d     c     r     f     l     e     miss   tog
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd2);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd3);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd4);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd5);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd6);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd7);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 16'd7);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 16'd7);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 16'd7);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 16'd8);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 16'd9);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 16'd10);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 16'd11);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'd11);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd11);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd12);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd13);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd14);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd15);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 16'd15);

        // Reset state while rst is held across edges.
        #12;
        chk_all("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].c);
            chk_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].f, vecs[i].l,
                    vecs[i].e, vecs[i].m, vecs[i].t);
        end

        // Acquisition aborted at run=2, then four fresh toggles to lock.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_all("acq_abort", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("acq_3_toggles_unlocked", {31'd0, locked}, 32'd0);
        step(1'b0, 1'b0);
        chk("acq_4_toggles_locked", {31'd0, locked}, 32'd1);
        chk("acq_no_err", {23'd0, err, miss_cnt}, 32'd0);

        // 300 lock/loss cycles saturate the miss counter.
        do_reset();
        cur = 1'b0;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) begin
                cur = ~cur;
                step(cur, 1'b0);
            end
            step(cur, 1'b0);
            if (i == 254) chk("miss_reach_255", {24'd0, miss_cnt}, 32'd255);
        end
        chk("miss_saturated", {24'd0, miss_cnt}, 32'd255);
        chk("sat_err_locked", {30'd0, err, locked}, 32'd2);
        chk("sat_tog_cnt", {16'd0, tog_cnt}, 32'd1200);

        // Continuous toggling: lock holds, tog_cnt wraps after 65536.
        do_reset();
        cur = 1'b0;
        for (int i = 1; i <= 65541; i++) begin
            cur = ~cur;
            step(cur, 1'b0);
            if (i == 20) begin
                chk("tog20_cnt", {16'd0, tog_cnt}, 32'd20);
                chk("tog20_locked_noerr", {30'd0, locked, err}, 32'd2);
            end
        end
        chk("tog_wrap", {16'd0, tog_cnt}, 32'd5);

        // Asynchronous reset mid-LOCK, between clock edges.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk_all("pre_async_lock", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst_immediate", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0);
        chk_all("post_rst_first_rise", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("post_rst_3_unlocked", {31'd0, locked}, 32'd0);
        step(1'b0, 1'b0);
        chk_all("post_rst_relock", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/toggle_monitor.md
TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter: LOCK_CNT, 4, consecutive toggles required to declare lock (range 2..15).
REQ-002 Parameter: MISS_W, 8, width of saturating miss counter.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: din  input  1  toggle stream from the upstream odd/even generator, synchronous to clk.
REQ-006 Port: clr_err  input  1  synchronous clear of err and miss_cnt.
REQ-007 Port: rise  output  1  one-cycle pulse, din 0->1 detected.
REQ-008 Port: fall  output  1  one-cycle pulse, din 1->0 detected.
REQ-009 Port: locked  output  1  high only while FSM is in LOCK.
REQ-010 Port: err  output  1  sticky, set on loss of lock.
REQ-011 Port: miss_cnt  output  MISS_W  count of lock losses, saturating.
REQ-012 Port: tog_cnt  output  16  count of all toggles, wrapping.

Function
REQ-013 din SHALL be sampled into din_q every cycle; toggle = din XOR din_q, miss = NOT toggle.
REQ-014 rise/fall SHALL be registered: asserted the cycle after the sampling edge that saw the transition (latency 1), never both high.
REQ-015 tog_cnt SHALL increment by 1 per toggle, 16'hFFFF wraps to 0.
REQ-016 FSM states: IDLE, ACQ, LOCK, FAULT; reset state IDLE; internal run counter 4 bits.
REQ-017 IDLE: toggle -> ACQ, run=1; miss -> stay IDLE.
REQ-018 ACQ: toggle -> run+1, and when run+1 == LOCK_CNT -> LOCK; miss -> IDLE, run=0.
REQ-019 LOCK: toggle -> stay; miss -> FAULT, err<=1, miss_cnt+1 (hold at all-ones).
REQ-020 FAULT: toggle -> ACQ, run=1; miss -> stay FAULT (no further miss_cnt increments).
REQ-021 locked SHALL be a registered decode of state==LOCK, asserting the cycle the FSM enters LOCK.
REQ-022 clr_err SHALL clear err and miss_cnt on the next edge; it does not change FSM state.
REQ-023 clr_err coincident with a LOCK->FAULT miss: miss wins, err=1, miss_cnt=1.
REQ-024 din_q resets to 0, so din=1 on the first sampling edge after reset counts as a toggle and a rise.

Reset
REQ-025 rst asserted SHALL immediately force din_q=0, state=IDLE, run=0, rise=fall=locked=err=0, miss_cnt=0, tog_cnt=0.
REQ-026 rst mid-LOCK SHALL abort lock with no err set; after release, a full LOCK_CNT toggle run is required again.
REQ-027 Reset deassertion SHALL be usable asynchronously; first functional update occurs on the next rising clk edge.

Structure
REQ-028 Package toggle_monitor_pkg SHALL hold the state enum, LOCK_CNT default, MISS_W default and counter widths.
REQ-029 One sub-module, toggle_edge_detect (din -> din_q, toggle, rise, fall), SHALL be instantiated; FSM and counters stay in toggle_monitor.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Reset then din toggling every cycle from 0 -> locked=1 on the cycle after the 4th toggle, rise/fall alternate, tog_cnt=20 after 20 toggles, err=0.
REQ-032 Locked, then din held 1 for 3 cycles -> FAULT on the first missed edge: locked=0, err=1, miss_cnt=1; resume toggling -> relock after 4 toggles, err stays 1.
REQ-033 ACQ with run=2, then one miss -> back to IDLE, err=0, miss_cnt=0; 4 more toggles required to lock.
REQ-034 clr_err pulse in FAULT -> err=0, miss_cnt=0 next cycle, state unchanged; clr_err on the same edge as a LOCK miss -> err=1, miss_cnt=1.
REQ-035 300 lock/loss cycles -> miss_cnt saturates at 255; 65,536+5 toggles -> tog_cnt wraps to 5.
REQ-036 rst asserted mid-LOCK between clk edges -> all outputs 0 immediately; after release, behaves as in REQ-031.
